// File: rtl/nexys_starship_game_ctrl.sv
// Nexys Starship game controller: INIT/PLAY/PAUSE/GAMEOVER sequencing, lives, level and game-seconds timer.
// Latency: a button press or hit in cycle N is visible on every output from cycle N+1; all outputs are registered.
// Backpressure: none. Buttons are level inputs and are edge-detected internally, and hit is a single-cycle pulse.
//
// Ports:
//   Clk, Reset_n             clock and asynchronous active-low reset
//   BtnU / BtnC / BtnD       debounced start-resume / return-to-init / pause-toggle buttons
//   hit                      one-cycle ship-damage pulse
//   q_Init..q_GameOver       one-hot state; play_flag = PLAY or PAUSE; game_over = GAMEOVER
//   lives, level             remaining lives and current level (level starts at 1)
//   game_timer, sec_tick     elapsed game seconds (saturating) and one-cycle pulse per game second
module nexys_starship_game_ctrl #(
  parameter int LIVES      = 3,
  parameter int NUM_LEVELS = 4,
  parameter int LEVEL_SECS = 30,
  parameter int TICK_DIV   = 100000000,
  parameter int TIMER_W    = 16
) (
  input  logic                            Clk,
  input  logic                            Reset_n,
  input  logic                            BtnU,
  input  logic                            BtnC,
  input  logic                            BtnD,
  input  logic                            hit,
  output logic                            q_Init,
  output logic                            q_Play,
  output logic                            q_Pause,
  output logic                            q_GameOver,
  output logic                            play_flag,
  output logic                            game_over,
  output logic [$clog2(LIVES+1)-1:0]      lives,
  output logic [$clog2(NUM_LEVELS+1)-1:0] level,
  output logic [TIMER_W-1:0]              game_timer,
  output logic                            sec_tick
);

  localparam int LW = $clog2(LIVES + 1);
  localparam int VW = $clog2(NUM_LEVELS + 1);
  localparam int DW = $clog2(TICK_DIV);
  localparam int SW = $clog2(LEVEL_SECS + 1);

  localparam logic [LW-1:0] LIVES_INIT = LW'(LIVES);
  localparam logic [VW-1:0] LVL_ONE    = VW'(1);
  localparam logic [VW-1:0] LVL_MAX    = VW'(NUM_LEVELS);
  localparam logic [DW-1:0] DIV_LAST   = DW'(TICK_DIV - 1);
  localparam logic [SW-1:0] LSEC_LAST  = SW'(LEVEL_SECS - 1);

  typedef enum logic [3:0] {
    S_INIT  = 4'b0001,
    S_PLAY  = 4'b0010,
    S_PAUSE = 4'b0100,
    S_OVER  = 4'b1000
  } state_t;

  state_t          state;
  logic [DW-1:0]   div_cnt;
  logic [SW-1:0]   lsec_cnt;
  logic            btn_u_prev;
  logic            btn_c_prev;
  logic            btn_d_prev;

  logic            press_u;
  logic            press_c;
  logic            press_d;
  logic            wrap;
  logic            fatal_hit;

  // The one-hot state register drives the state outputs directly, so they are registered.
  assign q_Init     = state[0];
  assign q_Play     = state[1];
  assign q_Pause    = state[2];
  assign q_GameOver = state[3];

  assign press_u   = BtnU & ~btn_u_prev;
  assign press_c   = BtnC & ~btn_c_prev;
  assign press_d   = BtnD & ~btn_d_prev;
  assign wrap      = (div_cnt == DIV_LAST);
  // A hit with at most one life left ends the game.
  assign fatal_hit = hit && (lives <= LW'(1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= S_INIT;
      play_flag  <= 1'b0;
      game_over  <= 1'b0;
      lives      <= LIVES_INIT;
      level      <= LVL_ONE;
      game_timer <= '0;
      sec_tick   <= 1'b0;
      div_cnt    <= '0;
      lsec_cnt   <= '0;
      btn_u_prev <= 1'b0;
      btn_c_prev <= 1'b0;
      btn_d_prev <= 1'b0;
    end else begin
      btn_u_prev <= BtnU;
      btn_c_prev <= BtnC;
      btn_d_prev <= BtnD;
      sec_tick   <= 1'b0;

      case (state)
        S_INIT: begin
          // Values left over from the previous game stay on display until a new game starts.
          if (press_u) begin
            state      <= S_PLAY;
            play_flag  <= 1'b1;
            game_over  <= 1'b0;
            lives      <= LIVES_INIT;
            level      <= LVL_ONE;
            game_timer <= '0;
            div_cnt    <= '0;
            lsec_cnt   <= '0;
          end
        end

        S_PLAY: begin
          if (fatal_hit) begin
            // The game ends on this edge, so a coincident tick or pause press is dropped.
            lives     <= '0;
            state     <= S_OVER;
            play_flag <= 1'b0;
            game_over <= 1'b1;
          end else if (press_c) begin
            state     <= S_INIT;
            play_flag <= 1'b0;
          end else begin
            if (hit) begin
              lives <= lives - LW'(1);
            end
            div_cnt <= wrap ? '0 : div_cnt + DW'(1);
            if (wrap) begin
              if (game_timer != '1) begin
                game_timer <= game_timer + TIMER_W'(1);
              end
              // The level-second counter keeps cycling after the level has saturated.
              if (lsec_cnt == LSEC_LAST) begin
                lsec_cnt <= '0;
                if (level != LVL_MAX) begin
                  level <= level + LVL_ONE;
                end
              end else begin
                lsec_cnt <= lsec_cnt + SW'(1);
              end
            end
            // A second that completes on the pausing edge is counted but not pulsed,
            // because sec_tick is held low while paused.
            if (press_d) begin
              state <= S_PAUSE;
            end else begin
              sec_tick <= wrap;
            end
          end
        end

        S_PAUSE: begin
          if (press_c) begin
            state     <= S_INIT;
            play_flag <= 1'b0;
          end else if (press_d || press_u) begin
            state <= S_PLAY;
          end
        end

        S_OVER: begin
          if (press_c) begin
            state     <= S_INIT;
            game_over <= 1'b0;
          end
        end

        default: begin
          // An illegal or non-one-hot state recovers exactly as if reset were applied.
          state      <= S_INIT;
          play_flag  <= 1'b0;
          game_over  <= 1'b0;
          lives      <= LIVES_INIT;
          level      <= LVL_ONE;
          game_timer <= '0;
          div_cnt    <= '0;
          lsec_cnt   <= '0;
          btn_u_prev <= 1'b0;
          btn_c_prev <= 1'b0;
          btn_d_prev <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nexys_starship_game_ctrl.sv
// Directed bench for nexys_starship_game_ctrl: a per-cycle vector table plus hand-written reset and saturation sequences.
// Inputs are driven on the falling edge, and outputs are sampled on the next falling edge.
// A second instance with a 2-bit timer covers timer saturation.
module tb_nexys_starship_game_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       BtnU, BtnC, BtnD, hit;
  logic       q_Init, q_Play, q_Pause, q_GameOver, play_flag, game_over;
  logic [1:0] lives, level;
  logic [15:0] game_timer;
  logic       sec_tick;

  logic       u2;
  logic       zero2;
  logic       q_Init2, q_Play2, q_Pause2, q_GameOver2, play_flag2, game_over2;
  logic [1:0] lives2, level2, game_timer2;
  logic       sec_tick2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  nexys_starship_game_ctrl #(
    .LIVES(3), .NUM_LEVELS(3), .LEVEL_SECS(2), .TICK_DIV(4), .TIMER_W(16)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .BtnU(BtnU), .BtnC(BtnC), .BtnD(BtnD), .hit(hit),
    .q_Init(q_Init), .q_Play(q_Play), .q_Pause(q_Pause), .q_GameOver(q_GameOver),
    .play_flag(play_flag), .game_over(game_over), .lives(lives), .level(level),
    .game_timer(game_timer), .sec_tick(sec_tick)
  );

  nexys_starship_game_ctrl #(
    .LIVES(3), .NUM_LEVELS(3), .LEVEL_SECS(2), .TICK_DIV(4), .TIMER_W(2)
  ) dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .BtnU(u2), .BtnC(zero2), .BtnD(zero2), .hit(zero2),
    .q_Init(q_Init2), .q_Play(q_Play2), .q_Pause(q_Pause2), .q_GameOver(q_GameOver2),
    .play_flag(play_flag2), .game_over(game_over2), .lives(lives2), .level(level2),
    .game_timer(game_timer2), .sec_tick(sec_tick2)
  );

  // State encoding in the bench: {GameOver, Pause, Play, Init}.
  localparam logic [3:0] I = 4'b0001, P = 4'b0010, S = 4'b0100, G = 4'b1000;

  typedef struct {
    logic       u, c, d, h;
    logic [3:0] st;
    logic [1:0] lives;
    logic [1:0] level;
    logic [15:0] timer;
    logic       tick;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic u, c, d, h, input logic [3:0] st,
                     input int lv, input int lvl, input int tm, input logic tk);
    vec_t v;
    v.u = u; v.c = c; v.d = d; v.h = h; v.st = st;
    v.lives = 2'(lv); v.level = 2'(lvl); v.timer = 16'(tm); v.tick = tk;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    logic [3:0] st;
    st = {q_GameOver, q_Pause, q_Play, q_Init};
    n_tests++;
    if (st !== v.st || play_flag !== (v.st[1] | v.st[2]) || game_over !== v.st[3] ||
        lives !== v.lives || level !== v.level || game_timer !== v.timer || sec_tick !== v.tick) begin
      n_fail++;
      $display("FAIL vec%0d: got st=%b pf=%b go=%b lives=%0d level=%0d timer=%0d tick=%b, expected st=%b lives=%0d level=%0d timer=%0d tick=%b",
               idx, st, play_flag, game_over, lives, level, game_timer, sec_tick,
               v.st, v.lives, v.level, v.timer, v.tick);
    end
  endtask

  task automatic drive(input logic u, c, d, h);
    BtnU = u; BtnC = c; BtnD = d; hit = h;
  endtask

  initial begin
    Reset_n = 1'b0;
    drive(0, 0, 0, 0);
    u2 = 1'b0;
    zero2 = 1'b0;

    // Table: start, 24 cycles of play, hits ending in game over, return to INIT, pause and resume.
    add(1,0,0,0, P,3,1,0,0);
    for (int k = 1; k <= 24; k++) begin
      int t;
      t = k / 4;
      add(0,0,0,0, P, 3, (t >= 4) ? 3 : (t >= 2) ? 2 : 1, t, (k % 4) == 0);
    end
    add(0,0,0,1, P,2,3,6,0);
    add(0,0,0,0, P,2,3,6,0);
    add(0,0,0,1, P,1,3,6,0);
    add(0,0,1,1, G,0,3,6,0);   // fatal hit beats pressD and the coincident tick
    add(0,0,0,0, G,0,3,6,0);
    add(0,0,0,1, G,0,3,6,0);
    add(0,1,0,0, I,0,3,6,0);   // BtnC held for 5 cycles gives a single move to INIT
    add(0,1,0,0, I,0,3,6,0);
    add(0,1,0,1, I,0,3,6,0);
    add(0,1,1,0, I,0,3,6,0);
    add(0,1,0,0, I,0,3,6,0);
    add(1,0,0,0, P,3,1,0,0);   // new game re-initialises
    add(0,0,0,0, P,3,1,0,0);
    add(0,0,0,0, P,3,1,0,0);
    add(0,0,0,0, P,3,1,0,0);
    add(0,0,0,0, P,3,1,1,1);
    add(0,0,1,0, S,3,1,1,0);   // pause with the divider frozen at 1
    for (int k = 0; k < 9; k++) add(0,0,1,(k == 2), S,3,1,1,0);
    add(0,0,0,0, S,3,1,1,0);
    add(0,0,1,0, P,3,1,1,0);   // resume
    add(0,0,0,0, P,3,1,1,0);
    add(0,0,0,0, P,3,1,1,0);
    add(0,0,0,0, P,3,2,2,1);   // tick after the remaining divider count
    add(0,0,1,1, S,2,2,2,0);   // non-fatal hit still applied on the pausing edge
    add(0,0,0,0, S,2,2,2,0);
    add(1,0,0,0, P,2,2,2,0);   // BtnU also resumes
    add(0,0,0,0, P,2,2,2,0);
    add(0,0,0,0, P,2,2,2,0);
    add(0,0,1,0, S,2,2,3,0);   // tick on the pausing edge is counted
    add(0,0,0,0, S,2,2,3,0);
    add(0,0,1,0, P,2,2,3,0);
    add(0,0,0,0, P,2,2,3,0);
    add(0,1,1,0, I,2,2,3,0);   // pressC beats pressD
    add(0,0,0,0, I,2,2,3,0);

    repeat (2) @(negedge Clk);
    chk("reset_q_Init", q_Init, 1);
    chk("reset_q_Play", q_Play, 0);
    chk("reset_play_flag", play_flag, 0);
    chk("reset_game_over", game_over, 0);
    chk("reset_lives", lives, 3);
    chk("reset_level", level, 1);
    chk("reset_timer", game_timer, 0);
    chk("reset_tick", sec_tick, 0);
    Reset_n = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].u, vq[i].c, vq[i].d, vq[i].h);
      @(negedge Clk);
      check_vec(i, vq[i]);
    end

    // Asynchronous reset mid-PLAY, applied between clock edges.
    drive(1, 0, 0, 0); @(negedge Clk);
    drive(0, 0, 0, 1); @(negedge Clk);
    drive(0, 0, 0, 0); repeat (3) @(negedge Clk);
    chk("pre_reset_timer", game_timer, 1);
    chk("pre_reset_lives", lives, 2);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_q_Init", q_Init, 1);
    chk("async_q_Play", q_Play, 0);
    chk("async_play_flag", play_flag, 0);
    chk("async_lives", lives, 3);
    chk("async_timer", game_timer, 0);
    chk("async_level", level, 1);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Timer saturation on the 2-bit instance.
    u2 = 1'b1; @(negedge Clk);
    u2 = 1'b0;
    chk("sat_play", q_Play2, 1);
    repeat (8) @(negedge Clk);
    chk("sat_timer_2s", game_timer2, 2);
    repeat (4) @(negedge Clk);
    chk("sat_timer_3s", game_timer2, 3);
    chk("sat_tick", sec_tick2, 1);
    repeat (12) @(negedge Clk);
    chk("sat_timer_hold", game_timer2, 3);
    chk("sat_level", level2, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
